// File: rtl/rrd_stage_pkg.sv
// Shared types and constants for the register-read stage.
//   iss_bundle_t : op leaving the issue unit (opid[15] = valid)
//   red_bundle_t : redirect request (opid[15] = valid, topid = oldest in flight)
//   exe_bundle_t : writeback result used for same-cycle bypass
//   rrd_bundle_t : op plus captured operand values handed to the function units
//   succeed()    : true when an op is younger than the redirecting op
package rrd_stage_pkg;

    localparam int unsigned iwd   = 4;
    localparam int unsigned ewd   = 4;
    localparam int unsigned opsz  = 64;
    localparam int unsigned prfsz = 128;
    localparam int unsigned xlen  = 64;
    localparam int unsigned nfu   = 5;

    localparam int unsigned idw = $clog2(opsz);
    localparam int unsigned paw = $clog2(prfsz);
    localparam int unsigned opw = 16;
    localparam int unsigned rw  = 8;

    typedef struct packed {
        logic [opw-1:0]     opid;
        logic [1:0][rw-1:0] prsa;
        logic [1:0]         prsb;   // prsb[1]: store data not ready yet
        logic [rw-1:0]      prda;
    } iss_bundle_t;

    typedef struct packed {
        logic [opw-1:0] opid;
        logic [opw-1:0] topid;
    } red_bundle_t;

    typedef struct packed {
        logic [opw-1:0]  opid;
        logic [rw-1:0]   prda;
        logic [xlen-1:0] data;
    } exe_bundle_t;

    typedef struct packed {
        logic [opw-1:0]     opid;
        logic [1:0][rw-1:0] prsa;
        logic [1:0]         prsb;
        logic [rw-1:0]      prda;
        logic [xlen-1:0]    a_val;
        logic [xlen-1:0]    b_val;
        logic               b_pend;
    } rrd_bundle_t;

    // Ages are measured from topid with modulo-opsz subtraction. "age >= red_age + 1" is
    // written as ">" so the +1 can never wrap.
    function automatic logic succeed(input logic [opw-1:0] opid,
                                     input logic [opw-1:0] red_opid,
                                     input logic [opw-1:0] topid);
        logic [idw-1:0] d_op;
        logic [idw-1:0] d_red;
        d_op  = opid[idw-1:0] - topid[idw-1:0];
        d_red = red_opid[idw-1:0] - topid[idw-1:0];
        return d_op > d_red;
    endfunction

endpackage

// File: rtl/rrd_lane.sv
// One issue lane's 2-entry FIFO between register read and the function units.
//   clk, rst    : clock, synchronous active-low reset
//   enq_i       : write enq_data_i at the tail
//   deq_i       : pop the head (ignored when empty)
//   red_i       : redirect; younger entries are dropped and survivors compacted to the head
//   head_o      : head entry, all zero when the lane is empty
//   count_o     : occupancy, 0..2
module rrd_lane
    import rrd_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        enq_i,
    input  rrd_bundle_t enq_data_i,
    input  logic        deq_i,
    input  red_bundle_t red_i,
    output rrd_bundle_t head_o,
    output logic [1:0]  count_o
);

    rrd_bundle_t [1:0] ent_q, ent_d;
    logic [1:0]        count_q, count_d;
    logic              keep0, keep1;

    always_comb begin
        ent_d   = ent_q;
        count_d = count_q;
        keep0   = 1'b0;
        keep1   = 1'b0;

        // Pop first so a same-cycle flush only judges what is left behind.
        if (deq_i && count_d != 2'd0) begin
            ent_d[0] = ent_d[1];
            ent_d[1] = '0;
            count_d  = count_d - 2'd1;
        end

        if (red_i.opid[15]) begin
            keep0 = (count_d >= 2'd1) && !succeed(ent_d[0].opid, red_i.opid, red_i.topid);
            keep1 = (count_d == 2'd2) && !succeed(ent_d[1].opid, red_i.opid, red_i.topid);
            unique case ({keep1, keep0})
                2'b11: begin
                    count_d = 2'd2;
                end
                2'b01: begin
                    ent_d[1] = '0;
                    count_d  = 2'd1;
                end
                2'b10: begin
                    ent_d[0] = ent_d[1];
                    ent_d[1] = '0;
                    count_d  = 2'd1;
                end
                default: begin
                    ent_d   = '0;
                    count_d = 2'd0;
                end
            endcase
        end

        if (enq_i && count_d != 2'd2) begin
            ent_d[count_d[0]] = enq_data_i;
            count_d           = count_d + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ent_q   <= '0;
            count_q <= 2'd0;
        end else begin
            ent_q   <= ent_d;
            count_q <= count_d;
        end
    end

    assign head_o  = ent_q[0];
    assign count_o = count_q;

    // The top only enqueues into a lane whose registered count is below 2.
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
                                     !(enq_i && count_q == 2'd2));
    a_count_range : assert property (@(posedge clk) disable iff (!rst) count_q != 2'd3);

endmodule

// File: rtl/rrd_stage.sv
// Register-read stage between the issue unit and the function units.
//   clk, rst    : clock, synchronous active-low reset
//   iss_bundle  : issued ops per lane; issue : per-lane accept, from registered counts only
//   red_bundle  : redirect, flushes younger buffered ops and blocks accepts that cycle
//   exe_bundle  : writeback results bypassed into operands captured this cycle
//   rf_raddr    : register file read addresses; rf_rdata : same-cycle read data
//   fu_stall    : per-FU-class stall; fu_ready : registered ready back to issue selection
//   rrd_bundle  : lane heads with operands; fu_ack : FU consumed the head of lane i
module rrd_stage
    import rrd_stage_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst,
    input  iss_bundle_t [iwd-1:0]           iss_bundle,
    output logic [iwd-1:0]                  issue,
    input  red_bundle_t                     red_bundle,
    input  exe_bundle_t [ewd-1:0]           exe_bundle,
    output logic [iwd-1:0][1:0][paw-1:0]    rf_raddr,
    input  logic [iwd-1:0][1:0][xlen-1:0]   rf_rdata,
    input  logic [nfu-1:0]                  fu_stall,
    output logic [nfu-1:0]                  fu_ready,
    output rrd_bundle_t [iwd-1:0]           rrd_bundle,
    input  logic [iwd-1:0]                  fu_ack
);

    logic [iwd-1:0][1:0]  lane_cnt;
    logic [iwd-1:0]       lane_free;
    logic [iwd-1:0]       enq;
    logic [iwd-1:0]       deq;
    rrd_bundle_t [iwd-1:0] enq_data;
    logic [nfu-1:0]       fu_ready_q;
    logic                 exe_unused;

    // Later writeback ports override earlier ones; register 0 is hard-wired to zero.
    function automatic logic [xlen-1:0] read_operand(input logic [paw-1:0] addr,
                                                     input logic [xlen-1:0] rf_val,
                                                     input exe_bundle_t [ewd-1:0] exe);
        logic [xlen-1:0] val;
        val = rf_val;
        for (int j = 0; j < ewd; j++) begin
            if (exe[j].opid[15] && exe[j].prda[paw-1:0] == addr) begin
                val = exe[j].data;
            end
        end
        if (addr == '0) begin
            val = '0;
        end
        return val;
    endfunction

    always_comb begin
        issue    = '0;
        enq      = '0;
        deq      = '0;
        rf_raddr = '0;
        enq_data = '0;
        lane_free = '0;
        for (int i = 0; i < iwd; i++) begin
            lane_free[i] = lane_cnt[i] < 2'd2;
            issue[i]     = rst && lane_free[i] && !red_bundle.opid[15];
            enq[i]       = iss_bundle[i].opid[15] && issue[i];
            deq[i]       = rrd_bundle[i].opid[15] && fu_ack[i];

            rf_raddr[i][0] = iss_bundle[i].prsa[0][paw-1:0];
            rf_raddr[i][1] = iss_bundle[i].prsa[1][paw-1:0];

            enq_data[i].opid  = iss_bundle[i].opid;
            enq_data[i].prsa  = iss_bundle[i].prsa;
            enq_data[i].prsb  = iss_bundle[i].prsb;
            enq_data[i].prda  = iss_bundle[i].prda;
            enq_data[i].a_val = read_operand(iss_bundle[i].prsa[0][paw-1:0], rf_rdata[i][0],
                                             exe_bundle);
            if (iss_bundle[i].prsb[1]) begin
                // Store data not ready: the FU asks for it again through issue resend.
                enq_data[i].b_val  = '0;
                enq_data[i].b_pend = 1'b1;
            end else begin
                enq_data[i].b_val  = read_operand(iss_bundle[i].prsa[1][paw-1:0],
                                                  rf_rdata[i][1], exe_bundle);
                enq_data[i].b_pend = 1'b0;
            end
        end
    end

    always_comb begin
        exe_unused = 1'b0;
        for (int j = 0; j < ewd; j++) begin
            exe_unused = exe_unused ^ (^exe_bundle[j].opid[14:0]) ^
                         (^exe_bundle[j].prda[rw-1:paw]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fu_ready_q <= '0;
        end else begin
            fu_ready_q <= ~fu_stall & {nfu{|lane_free}};
        end
    end

    assign fu_ready = fu_ready_q;

    for (genvar i = 0; i < iwd; i++) begin : g_lane
        rrd_lane u_lane (
            .clk        (clk),
            .rst        (rst),
            .enq_i      (enq[i]),
            .enq_data_i (enq_data[i]),
            .deq_i      (deq[i]),
            .red_i      (red_bundle),
            .head_o     (rrd_bundle[i]),
            .count_o    (lane_cnt[i])
        );
    end

endmodule

// File: doc/rrd_stage.md
Name: rrd_stage

Overview:
- Register-read stage sitting directly downstream of the issue unit.
- Consumes iss_bundle lanes and returns the per-lane `issue` accept signal.
- Reads the physical register file, bypasses same-cycle writeback results from exe_bundle, and buffers each lane in a 2-entry queue before handing rrd_bundle to the function units.
- Produces the 5-bit fu_ready vector consumed by issue selection, and flushes on redirect.

Parameters:
- iwd, 4, issue width (lanes)
- ewd, 4, execute/writeback width
- opsz, 64, operation ID space; wrap arithmetic uses $clog2(opsz) bits
- prfsz, 128, physical register count; address width $clog2(prfsz)
- xlen, 64, operand data width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low (reset when rst==0)
- iss_bundle  in  iwd x iss_bundle_t  issued ops; opid[15] = valid
- issue  out  iwd  lane accept; registered-state based
- red_bundle  in  red_bundle_t  redirect (opid, topid)
- exe_bundle  in  ewd x exe_bundle_t  writeback; opid[15] valid, prda, data
- rf_raddr  out  iwd x 2 x $clog2(prfsz)  register file read addresses
- rf_rdata  in  iwd x 2 x xlen  register file data, same-cycle combinational
- fu_stall  in  5  per-FU-class stall
- fu_ready  out  5  per-FU-class ready, to issue unit
- rrd_bundle  out  iwd x rrd_bundle_t  op plus operand values a_val, b_val, b_pend
- fu_ack  in  iwd  FU consumed head of lane i

Behaviour:
- Reset (rst==0):
  - All lane counts are 0 and all valid bits are 0.
  - issue, fu_ready and rrd_bundle are all 0 during reset.
  - Reset mid-operation drops all buffered ops.
- issue[i] = (count_i < 2) & ~red_bundle.opid[15].
  - It depends only on registered count, so there is no comb path from fu_ack.
  - A lane at count 2 with a same-cycle dequeue still shows issue=0.
- Accept: iss_bundle[i].opid[15] & issue[i].
  - The entry is written at the tail.
  - It is visible on rrd_bundle[i] at N+1 at the earliest, when the lane was empty.
- Operand capture occurs in the accept cycle only:
  - rf_raddr[i][k] = iss_bundle[i].prsa[k], truncated to $clog2(prfsz).
  - Value = rf_rdata, overridden by any valid exe_bundle[j] whose prda matches. Highest j wins.
  - Register 0 always reads 0 and is never bypassed.
- Pending b operand: if iss_bundle[i].prsb[1]==1 (store data not ready), set b_pend=1 and b_val=0. The downstream FU re-requests via the issue unit's resend.
- Dequeue: rrd_bundle[i].opid[15] & fu_ack[i] pops the head.
  - Enqueue and dequeue in the same cycle keep count unchanged.
  - fu_ack with an empty lane is ignored.
- Flush: when red_bundle.opid[15] is set, every buffered entry with succeed(opid) is invalidated in the same cycle.
  - succeed compares modulo $clog2(opsz): (opid-topid) >= (red.opid-topid)+1.
  - Surviving entries compact toward the head, preserving order.
  - No accepts occur during a redirect cycle.
- fu_ready[k] is registered and equals ~fu_stall[k] & (some lane has count < 2), sampled at the previous edge.
- Order within a lane is FIFO. There is no cross-lane ordering guarantee.
- Width rules:
  - Count is 2 bits, saturating at 2. Overflow is impossible by construction; an assertion covers it.
  - ID wrap uses unsigned modulo subtraction only.

Decomposition:
- types package:
  - Add rrd_bundle_t (iss_bundle_t fields + a_val, b_val [xlen-1:0], b_pend).
  - Add data field to exe_bundle_t if not already present.
  - Move the succeed() redirect comparison into the package as a shared function parameterised by opsz.
- Sub-module rrd_lane: one 2-entry buffer with enqueue, dequeue, flush-compaction and count.
  - Instantiated iwd times.
  - The top level handles register file addressing, bypass, fu_ready and issue.

Test Plan:
- Single op lane 0, prsa={5,6}, rf returns 0x11/0x22, fu_ack=1 → rrd_bundle[0] valid next cycle with a_val=0x11, b_val=0x22; count back to 0.
- Same-cycle bypass: accept with prsa[0]=5 while exe_bundle[1].prda=5, data=0xAA and exe_bundle[3].prda=5, data=0xBB → a_val=0xBB.
- Backpressure: fu_ack=0 for 3 accepts on lane 2 → issue[2] falls to 0 after the 2nd accept, and the 3rd op is not accepted; one fu_ack → issue[2]=1 on the following cycle.
- Redirect: lane buffers hold opid 0x8003, 0x8005; red opid=0x8004, topid=0x8000 → 0x8005 dropped, 0x8003 kept at head; issue=0 that cycle.
- Wrap-around: topid=0x803E, buffered 0x803F and 0x8001, red opid=0x803F → 0x8001 flushed, 0x803F kept.
- Reset mid-stream: rst=0 with full lanes → next cycle issue=0, fu_ready=0, all rrd_bundle opid[15]=0; after rst=1, issue=all ones.
